sar_adc_ctrl: RTL and testbench
===============================

# sar_adc_ctrl

Successive-approximation controller for the analog-to-digital converter. On a start request it sequences one track phase and N binary-search bit trials. For each trial it drives a trial code to the DAC, waits a programmable settle time, samples the external comparator, and keeps or clears the bit. It sits between the top-level converter control and the DAC/comparator analog models, and produces the final N-bit code with a one-cycle done strobe.

## Interface
Parameters:
- N, 8, conversion resolution in bits (N >= 2)
- SAMPLE_CYC, 2, cycles SAMPLE is held high per conversion (>= 1)
- SETTLE_CYC, 1, cycles allowed per bit trial before CMP is sampled (>= 1)

Ports:
- CLK  in  1  sole clock, rising-edge
- CLRbar  in  1  reset, asynchronous, active-high (clears when 1 despite the name)
- START  in  1  conversion request, sampled only in IDLE
- CMP  in  1  comparator result, 1 when Vin >= Vdac(DAC)
- SAMPLE  out  1  track/hold control, 1 = track
- DAC  out  N  trial code to the DAC
- BUSY  out  1  conversion in progress
- DONE  out  1  one-cycle strobe, DOUT valid and newly updated
- DOUT  out  N  last completed conversion result

## Operation
- Reset values (while CLRbar = 1): state IDLE; SAMPLE, BUSY and DONE are 0; DAC and DOUT are all zeros; counters are 0.
- States are IDLE, SAMP and CONV. The trial register drives DAC directly. The bit index idx runs from N-1 down to 0.
- IDLE: if START = 1 at an edge, go to SAMP and load cnt = SAMPLE_CYC-1. Set trial = 1 << (N-1), so the DAC pre-settles at midscale during tracking.
- SAMP: SAMPLE = 1 and BUSY = 1.
  - If cnt = 0: go to CONV, set idx = N-1 and cnt = SETTLE_CYC-1.
  - Otherwise decrement cnt.
- CONV: SAMPLE = 0 and BUSY = 1.
  - If cnt ≠ 0: decrement cnt.
  - If cnt = 0 (decision edge): if CMP = 0, clear trial[idx].
  - If idx > 0 at the decision edge: set trial[idx-1], decrement idx, reload cnt = SETTLE_CYC-1.
  - If idx = 0 at the decision edge: load DOUT with the final trial, including the bit-0 decision. Assert DONE for exactly one cycle and return to IDLE.
- CMP is ignored at every edge other than a decision edge.
- After completion, DAC holds the final code until the next accepted START.
- START while BUSY = 1 is ignored; requests are not queued.
- DONE and BUSY are never both 1. DONE is asserted in the first IDLE cycle after a conversion.
- A START present in the DONE cycle is accepted: back-to-back conversions with no idle gap.
- CLRbar asserted mid-conversion aborts at once. All outputs take their reset values, including DOUT = 0. No DONE is issued. The next conversion needs a fresh START after CLRbar falls.
- Width rules:
  - idx is clog2(N) bits.
  - cnt is clog2(max(SAMPLE_CYC, SETTLE_CYC)) bits, minimum 1.
  - No arithmetic on the data path beyond single-bit set and clear.

## Timing
- Let edge 0 be the edge that accepts START.
- SAMPLE is high during cycles 1..SAMPLE_CYC.
- Bit k (from MSB, k = 0..N-1) is decided at edge SAMPLE_CYC + (k+1)·SETTLE_CYC.
- DONE is high in the cycle after edge SAMPLE_CYC + N·SETTLE_CYC. DOUT updates on the same edge.
- Defaults (N=8, SAMPLE_CYC=2, SETTLE_CYC=1): DONE rises 10 edges after START acceptance.
- Conversion period for back-to-back operation is SAMPLE_CYC + N·SETTLE_CYC + 1 cycles.
- All outputs are registered. There is no combinational path from START or CMP to any output.

## Structure
- Shared header sar_adc_defs.vh holds:
  - state encodings: IDLE = 2'b00, SAMP = 2'b01, CONV = 2'b10; 2'b11 recovers to IDLE
  - default values for N, SAMPLE_CYC and SETTLE_CYC
- One sub-module, sar_cycle_cnt: loadable down-counter with a zero flag, shared by SAMP and CONV.
- Trial register, idx and FSM stay in sar_adc_ctrl.

## Test plan
Bench CMP model: ideal comparator, CMP = (V >= DAC), evaluated combinationally from DAC.

- V = 8'hA5, START pulse → DAC sequence 80, C0, A0, B0, A8, A4, A6, A5; DONE at edge 10; DOUT = 8'hA5.
- V = 8'h00 and V = 8'hFF, separate conversions → DOUT = 8'h00 and 8'hFF respectively; DONE exactly one cycle each.
- START pulsed again at edges 3 and 7 of a conversion with V = 8'h3C → ignored; single DONE at edge 10; DOUT = 8'h3C.
- START held high continuously, V = 8'h5A then 8'h21 → DONE every 11 cycles; DOUT = 8'h5A then 8'h21; BUSY low only in DONE cycles.
- CLRbar pulsed at edge 6 of a conversion → SAMPLE/BUSY/DONE/DAC/DOUT all 0 immediately; no DONE; a later START with V = 8'h77 yields DOUT = 8'h77.
- SETTLE_CYC = 3, SAMPLE_CYC = 1, V = 8'h81 → each DAC code held 3 cycles; CMP toggled at non-decision edges has no effect; DONE at edge 25; DOUT = 8'h81.

Source files
------------

// File: rtl/sar_adc_ctrl_pkg.sv
// Shared definitions for the SAR ADC controller: state encodings, default
// geometry and the settle/sample counter width helper.
package sar_adc_ctrl_pkg;

  localparam int DEF_N          = 8;
  localparam int DEF_SAMPLE_CYC = 2;
  localparam int DEF_SETTLE_CYC = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SAMP = 2'b01,
    ST_CONV = 2'b10
  } state_t;

  // Counter must hold the larger of the two reload values; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sar_cycle_cnt.sv
// Loadable down-counter with a zero flag; times both the track phase and
// each bit-trial settle window.
module sar_cycle_cnt #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: one track phase followed by N
// binary-search trials, each settled before the comparator is sampled.
module sar_adc_ctrl
  import sar_adc_ctrl_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic         CLK,
  input  logic         CLRbar,
  input  logic         START,
  input  logic         CMP,
  output logic         SAMPLE,
  output logic [N-1:0] DAC,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] DOUT
);

  localparam int IW = $clog2(N);
  localparam int CW = cnt_width(SAMPLE_CYC, SETTLE_CYC);
  localparam logic [CW-1:0] SAMP_LOAD   = CW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [IW-1:0] IDX_MSB     = IW'(N - 1);

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_trial;
  logic [N-1:0]  r_dout;
  logic          r_sample;
  logic          r_busy;
  logic          r_done;

  logic          w_cnt_zero;
  logic          w_cnt_load;
  logic          w_cnt_dec;
  logic [CW-1:0] w_cnt_val;
  logic          w_idx_last;
  logic [IW-1:0] w_idx_dn;

  assign w_idx_last = (r_idx == '0);
  assign w_idx_dn   = r_idx - IW'(1);

  // Counter reloads on entry to each timed window and otherwise counts down to zero.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_cnt_val  = SETTLE_LOAD;
    case (r_state)
      ST_IDLE: begin
        w_cnt_load = START;
        w_cnt_val  = SAMP_LOAD;
      end
      ST_SAMP: begin
        w_cnt_load = w_cnt_zero;
        w_cnt_dec  = !w_cnt_zero;
      end
      ST_CONV: begin
        w_cnt_load = w_cnt_zero && !w_idx_last;
        w_cnt_dec  = !w_cnt_zero;
      end
      default: ;
    endcase
  end

  sar_cycle_cnt #(.W(CW)) u_cnt (
    .i_clk      (CLK),
    .i_rst      (CLRbar),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge CLK or posedge CLRbar) begin
    if (CLRbar) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_trial  <= '0;
      r_dout   <= '0;
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_state  <= ST_SAMP;
            r_sample <= 1'b1;
            r_busy   <= 1'b1;
            r_trial  <= {1'b1, {(N-1){1'b0}}};
          end
        end
        ST_SAMP: begin
          if (w_cnt_zero) begin
            r_state  <= ST_CONV;
            r_sample <= 1'b0;
            r_idx    <= IDX_MSB;
          end
        end
        ST_CONV: begin
          if (w_cnt_zero) begin
            if (w_idx_last) begin
              // Bit 0 is still set here, so its final value is just the comparator.
              r_trial[0] <= CMP;
              r_dout     <= {r_trial[N-1:1], CMP};
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              if (!CMP) r_trial[r_idx] <= 1'b0;
              r_trial[w_idx_dn] <= 1'b1;
              r_idx             <= w_idx_dn;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_sample <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign SAMPLE = r_sample;
  assign DAC    = r_trial;
  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign DOUT   = r_dout;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: ideal comparator in the loop, expected
// DAC/DOUT derived from the input voltage and the edge timing rules.
module tb_sar_adc_ctrl;

  logic       clk;
  logic       clr;
  logic       start;
  logic       glitch;
  logic [7:0] vin;
  logic       sel;

  logic       sampleA, busyA, doneA, cmpA;
  logic [7:0] dacA, doutA;
  logic       sampleB, busyB, doneB, cmpB;
  logic [7:0] dacB, doutB;

  logic       sampleO, busyO, doneO;
  logic [7:0] dacO, doutO;

  int         vectors;
  int         miscompares;
  int         sampCyc;
  int         settleCyc;
  logic [7:0] lastDout;
  logic [7:0] lastDac;

  // Ideal comparator; glitch flips it only at edges where CMP must be ignored.
  assign cmpA = (vin >= dacA) ^ glitch;
  assign cmpB = (vin >= dacB) ^ glitch;

  sar_adc_ctrl #(.N(8), .SAMPLE_CYC(2), .SETTLE_CYC(1)) dutA (
    .CLK(clk), .CLRbar(clr), .START(start), .CMP(cmpA),
    .SAMPLE(sampleA), .DAC(dacA), .BUSY(busyA), .DONE(doneA), .DOUT(doutA)
  );

  sar_adc_ctrl #(.N(8), .SAMPLE_CYC(1), .SETTLE_CYC(3)) dutB (
    .CLK(clk), .CLRbar(clr), .START(start), .CMP(cmpB),
    .SAMPLE(sampleB), .DAC(dacB), .BUSY(busyB), .DONE(doneB), .DOUT(doutB)
  );

  assign sampleO = sel ? sampleB : sampleA;
  assign busyO   = sel ? busyB   : busyA;
  assign doneO   = sel ? doneB   : doneA;
  assign dacO    = sel ? dacB    : dacA;
  assign doutO   = sel ? doutB   : doutA;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // After d decided bits the DAC shows V's top d bits plus the next trial bit.
  function automatic logic [7:0] expDac(input logic [7:0] v, input int d);
    int keep;
    int r;
    keep = 256 - (1 << (8 - d));
    r    = (int'(v) & keep) | ((d < 8) ? (1 << (7 - d)) : 0);
    return 8'(r);
  endfunction

  task automatic checkZero(input string tag);
    checkOutput({tag, " sample"}, 32'(sampleO), 32'd0);
    checkOutput({tag, " busy"},   32'(busyO),   32'd0);
    checkOutput({tag, " done"},   32'(doneO),   32'd0);
    checkOutput({tag, " dac"},    32'(dacO),    32'd0);
    checkOutput({tag, " dout"},   32'(doutO),   32'd0);
  endtask

  task automatic resetDut();
    clr   = 1'b1;
    start = 1'b0;
    #1;
    checkZero("rst");
    @(posedge clk);
    @(negedge clk);
    checkZero("rst hold");
    clr      = 1'b0;
    lastDout = 8'h00;
    lastDac  = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    start = 1'b0;
    repeat (n) begin
      glitch = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      checkOutput("idle busy",   32'(busyO),   32'd0);
      checkOutput("idle done",   32'(doneO),   32'd0);
      checkOutput("idle sample", 32'(sampleO), 32'd0);
      checkOutput("idle dac",    32'(dacO),    32'(lastDac));
      checkOutput("idle dout",   32'(doutO),   32'(lastDout));
    end
  endtask

  // One conversion starting at the next edge; abortAt > 0 pulses reset before that edge.
  task automatic applyStimulus(input logic [7:0] v, input bit hold, input int startMask, input int abortAt);
    int total;
    int d;
    int nxt;
    total  = sampCyc + 8 * settleCyc;
    vin    = v;
    start  = 1'b1;
    glitch = 1'($urandom_range(0, 1));
    for (int e = 0; e <= total; e++) begin
      @(posedge clk);
      @(negedge clk);
      d = (e < sampCyc) ? 0 : (e - sampCyc) / settleCyc;
      if (d > 8) d = 8;
      checkOutput($sformatf("sample e%0d", e), 32'(sampleO), 32'(e < sampCyc));
      checkOutput($sformatf("busy e%0d", e),   32'(busyO),   32'(e < total));
      checkOutput($sformatf("done e%0d", e),   32'(doneO),   32'(e == total));
      checkOutput($sformatf("dac e%0d", e),    32'(dacO),    32'(expDac(v, d)));
      checkOutput($sformatf("dout e%0d", e),   32'(doutO),   32'((e == total) ? v : lastDout));
      if (abortAt > 0 && e == abortAt - 1) begin
        clr   = 1'b1;
        start = 1'b0;
        #1;
        checkZero("abort");
        @(posedge clk);
        @(negedge clk);
        checkZero("abort hold");
        clr      = 1'b0;
        lastDout = 8'h00;
        lastDac  = 8'h00;
        return;
      end
      nxt    = e + 1;
      start  = hold || (nxt < 32 && ((startMask >> nxt) & 1) != 0);
      glitch = (nxt >= sampCyc + settleCyc && nxt <= total && ((nxt - sampCyc) % settleCyc) == 0)
               ? 1'b0 : 1'($urandom_range(0, 1));
    end
    lastDout = v;
    lastDac  = v;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr         = 1'b0;
    start       = 1'b0;
    glitch      = 1'b0;
    vin         = 8'h00;
    sel         = 1'b0;
    sampCyc     = 2;
    settleCyc   = 1;
    lastDout    = 8'h00;
    lastDac     = 8'h00;
    @(negedge clk);
    resetDut();
    idleCycles(2);

    applyStimulus(8'hA5, 1'b0, 0, 0);
    idleCycles(2);
    applyStimulus(8'h00, 1'b0, 0, 0);
    idleCycles(2);
    applyStimulus(8'hFF, 1'b0, 0, 0);
    idleCycles(2);
    applyStimulus(8'h3C, 1'b0, (1 << 3) | (1 << 7), 0);
    idleCycles(3);
    applyStimulus(8'h5A, 1'b1, 0, 0);
    applyStimulus(8'h21, 1'b0, 0, 0);
    idleCycles(2);
    applyStimulus(8'h99, 1'b0, 0, 6);
    idleCycles(12);
    applyStimulus(8'h77, 1'b0, 0, 0);
    idleCycles(1);

    for (int i = 0; i < 10; i++) begin
      logic [7:0] v;
      bit         h;
      v = 8'($urandom);
      h = (i < 9) && ($urandom_range(0, 1) == 1);
      applyStimulus(v, h, 0, 0);
      if (!h) idleCycles($urandom_range(0, 3));
    end

    sel       = 1'b1;
    sampCyc   = 1;
    settleCyc = 3;
    resetDut();
    idleCycles(2);
    applyStimulus(8'h81, 1'b0, 0, 0);
    idleCycles(2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'($urandom), 1'b0, 0, 0);
      idleCycles($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
